cpu_bus_cmp: RTL

//  Lockstep bus checker between the reference-model CPU interface and the DUV CPU interface.
//  - Queues every reference bus cycle: address, data and read/write strobe.
//  - Pops one queued cycle per DUV bus cycle and compares them.
//  - Flags mismatches, a missing DUV response (timeout), an unexpected DUV cycle and queue overflow.
//  - Sits in tb_top between the two CPU interfaces; its status is read by tb_env.
//  - Tolerates the DUV lagging the reference by up to DEPTH bus cycles.

---
 rtl/cpu_bus_cmp.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_bus_cmp.sv
// Lockstep checker: queues reference CPU bus cycles and compares each DUV bus
// cycle against the oldest one, reporting mismatches, timeouts, strays and overflow.
module cpu_bus_cmp #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned MAX_LAG = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             b_rst,
  input  logic             en,
  input  logic             stop_on_err,
  input  logic             ref_valid,
  input  logic [15:0]      ref_addr,
  input  logic [7:0]       ref_data,
  input  logic             ref_rw,
  input  logic             duv_valid,
  input  logic [15:0]      duv_addr,
  input  logic [7:0]       duv_data,
  input  logic             duv_rw,
  output logic             mismatch,
  output logic [1:0]       err_code,
  output logic [15:0]      first_addr,
  output logic [7:0]       first_exp,
  output logic [7:0]       first_got,
  output logic [CNT_W-1:0] match_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             overflow,
  output logic [1:0]       state
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(MAX_LAG + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FAIL = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [24:0]      r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]    r_lag;
  logic             r_mismatch, r_overflow;
  logic [1:0]       r_err_code;
  logic [15:0]      r_first_addr;
  logic [7:0]       r_first_exp, r_first_got;
  logic [CNT_W-1:0] r_match_cnt, r_err_cnt;

  logic        w_run, w_empty, w_full;
  logic [24:0] w_head, w_ref_ent, w_duv_ent, w_cmp_ent;
  logic        w_bypass, w_unexp, w_ovf, w_pop_cmp, w_cmp, w_cmp_err;
  logic        w_push, w_timeout, w_pop, w_err;
  logic [1:0]  w_code;
  logic [15:0] w_f_addr;
  logic [7:0]  w_f_exp, w_f_got;

  assign w_run     = (r_state == S_RUN) && en;
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
  assign w_ref_ent = {ref_addr, ref_data, ref_rw};
  assign w_duv_ent = {duv_addr, duv_data, duv_rw};

  assign w_bypass  = w_run && w_empty && ref_valid && duv_valid;
  assign w_unexp   = w_run && w_empty && !ref_valid && duv_valid;
  assign w_ovf     = w_run && w_full && ref_valid && !duv_valid;
  assign w_pop_cmp = w_run && !w_empty && duv_valid;
  assign w_cmp     = w_bypass || w_pop_cmp;
  assign w_cmp_ent = w_empty ? w_ref_ent : w_head;
  assign w_cmp_err = w_cmp && (w_cmp_ent != w_duv_ent);
  // Full with a simultaneous pop still accepts the push (slot is freed this edge).
  assign w_push    = w_run && ref_valid && !w_bypass && !w_ovf;
  assign w_timeout = w_run && !w_empty && !duv_valid && (r_lag == LW'(MAX_LAG - 1));
  assign w_pop     = w_pop_cmp || w_timeout;
  assign w_err     = w_ovf || w_cmp_err || w_timeout || w_unexp;

  always_comb begin
    w_code   = 2'd0;
    w_f_addr = '0;
    w_f_exp  = '0;
    w_f_got  = '0;
    if (w_ovf) begin
      w_code   = 2'd3;
      w_f_addr = ref_addr;
      w_f_exp  = ref_data;
    end else if (w_cmp_err) begin
      w_code   = 2'd1;
      w_f_addr = w_cmp_ent[24:9];
      w_f_exp  = w_cmp_ent[8:1];
      w_f_got  = duv_data;
    end else if (w_timeout) begin
      w_code   = 2'd2;
      w_f_addr = w_head[24:9];
      w_f_exp  = w_head[8:1];
    end else if (w_unexp) begin
      w_code   = 2'd3;
      w_f_got  = duv_data;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (en) w_state_nxt = S_RUN;
      S_RUN: begin
        if (!en)                    w_state_nxt = S_IDLE;
        else if (w_err && stop_on_err) w_state_nxt = S_FAIL;
      end
      S_FAIL:  if (!en) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge b_rst) begin
    if (!b_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_ref_ent;
  end

  always_ff @(posedge clk or negedge b_rst) begin
    if (!b_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_lag    <= '0;
    end else if (!en) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_lag    <= '0;
    end else if (w_run) begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_lag <= (w_empty || w_pop) ? '0 : r_lag + LW'(1);
    end
  end

  always_ff @(posedge clk or negedge b_rst) begin
    if (!b_rst) begin
      r_mismatch   <= 1'b0;
      r_err_code   <= '0;
      r_first_addr <= '0;
      r_first_exp  <= '0;
      r_first_got  <= '0;
      r_match_cnt  <= '0;
      r_err_cnt    <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_mismatch <= w_err;
      if (w_cmp && !w_cmp_err && (r_match_cnt != '1))
        r_match_cnt <= r_match_cnt + 1'b1;
      if (w_ovf)
        r_overflow <= 1'b1;
      if (w_err) begin
        r_err_code <= w_code;
        if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + 1'b1;
        if (r_err_cnt == '0) begin
          r_first_addr <= w_f_addr;
          r_first_exp  <= w_f_exp;
          r_first_got  <= w_f_got;
        end
      end
    end
  end

  assign mismatch   = r_mismatch;
  assign err_code   = r_err_code;
  assign first_addr = r_first_addr;
  assign first_exp  = r_first_exp;
  assign first_got  = r_first_got;
  assign match_cnt  = r_match_cnt;
  assign err_cnt    = r_err_cnt;
  assign overflow   = r_overflow;
  assign state      = r_state;

endmodule
